// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// Purpose:
//   Multi-channel mechanical key debouncer. Every channel is filtered
//   independently: a new level is accepted only after STABLE_CNT consecutive
//   samples agree with it. On acceptance the channel produces a one-cycle
//   press (0->1) or release (1->0) pulse, and presses advance a 4-bit wrapping
//   counter that can drive a 7-segment digit directly.
//
// Parameters:
//   N_KEYS     - number of independent channels (>= 1)
//   STABLE_CNT - consecutive agreeing samples needed to accept a level (>= 1)
//   CNT_WIDTH  - stability counter width, 2**CNT_WIDTH > STABLE_CNT
//
// Ports:
//   clk         in   1         system clock, rising edge
//   clr         in   1         synchronous active-high reset
//   key_in      in   N_KEYS    raw bouncing key inputs, 1 = pressed
//   key_level   out  N_KEYS    debounced level per channel
//   key_press   out  N_KEYS    one-cycle pulse on accepted 0->1
//   key_release out  N_KEYS    one-cycle pulse on accepted 1->0
//   press_cnt   out  4*N_KEYS  per-channel press counter, channel i at [4i+3:4i]
//
// Build option:
//   KEY_DEBOUNCE_SYNC_EN - when defined, each key_in bit passes through a
//   two-flop synchroniser before the FSM (2 cycles extra latency). Leave it
//   undefined only when key_in is already synchronous to clk.
// -----------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int N_KEYS     = 4,
    parameter int STABLE_CNT = 20000,
    parameter int CNT_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [N_KEYS-1:0]     key_in,
    output logic [N_KEYS-1:0]     key_level,
    output logic [N_KEYS-1:0]     key_press,
    output logic [N_KEYS-1:0]     key_release,
    output logic [4*N_KEYS-1:0]   press_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // The counter holds the number of agreeing samples already seen, so the
    // sample that completes the run arrives while the counter is STABLE_CNT-1.
    // In an IDLE state the counter is always 0, which makes STABLE_CNT=1
    // accept straight from IDLE without visiting the WAIT state.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CNT - 1);

    // Sample seen by each channel FSM.
    logic [N_KEYS-1:0] key_samp;

`ifdef KEY_DEBOUNCE_SYNC_EN
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_samp = sync2_q;
`else
    assign key_samp = key_in;
`endif

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        state_e               state_q;
        state_e               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 level_q;
        logic                 level_d;
        logic                 press_q;
        logic                 press_d;
        logic                 release_q;
        logic                 release_d;
        logic [3:0]           pcnt_q;
        logic [3:0]           pcnt_d;

        // Per-channel next-state, counter and output decode.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            pcnt_d    = pcnt_q;
            case (state_q)
                IDLE_LOW, WAIT_HIGH: begin
                    if (key_samp[g]) begin
                        if (cnt_q == LAST_CNT) begin
                            state_d = IDLE_HIGH;
                            cnt_d   = CNT_ZERO;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            pcnt_d  = pcnt_q + 4'd1;
                        end else begin
                            state_d = WAIT_HIGH;
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end else begin
                        // A disagreeing sample throws away the whole run.
                        state_d = IDLE_LOW;
                        cnt_d   = CNT_ZERO;
                    end
                end
                IDLE_HIGH, WAIT_LOW: begin
                    if (!key_samp[g]) begin
                        if (cnt_q == LAST_CNT) begin
                            state_d   = IDLE_LOW;
                            cnt_d     = CNT_ZERO;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = WAIT_LOW;
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = IDLE_HIGH;
                        cnt_d   = CNT_ZERO;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end
            endcase
        end

        // Per-channel state, counter and registered outputs.
        always_ff @(posedge clk) begin
            if (clr) begin
                state_q   <= IDLE_LOW;
                cnt_q     <= CNT_ZERO;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                pcnt_q    <= 4'd0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                pcnt_q    <= pcnt_d;
            end
        end

        assign key_level[g]         = level_q;
        assign key_press[g]         = press_q;
        assign key_release[g]       = release_q;
        assign press_cnt[4*g +: 4]  = pcnt_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// Testbench for key_debounce_multi (N_KEYS=4, STABLE_CNT=4, CNT_WIDTH=3).
// A reference model built on a sliding window of the last STABLE_CNT samples
// predicts the outputs of every cycle; predictions are queued before the edge
// and compared once the DUT has produced its outputs. A table of phases and a
// few hand-written sequences add end-of-phase and timing checks.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    localparam int NK = 4;
    localparam int SC = 4;
    localparam int CW = 3;
`ifdef KEY_DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int ACC = LAT + SC;

    logic        clk    = 1'b0;
    logic        clr    = 1'b1;
    logic [3:0]  key_in = 4'b0000;
    logic [3:0]  key_level;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic [15:0] press_cnt;

    key_debounce_multi #(
        .N_KEYS    (NK),
        .STABLE_CNT(SC),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .press_cnt  (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  level;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        clr;
        logic [3:0]  keys;
        int          cycles;
        logic [3:0]  exp_level;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   press_seen[4];
    int   rel_seen[4];
    int   bounce[5];

    // Reference model state.
    logic [3:0] m_sync1, m_sync2, m_level, m_press, m_rel;
    logic [3:0] m_hist[SC];
    logic [3:0] m_cnt[4];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Advance the model by one clock edge using the inputs present now.
    // A channel flips when its last SC samples all differ from its level.
    function automatic exp_t model_edge();
        exp_t       e;
        logic [3:0] s;
        logic       all_diff;
        if (clr) begin
            m_sync1 = 4'b0000;
            m_sync2 = 4'b0000;
            m_level = 4'b0000;
            m_press = 4'b0000;
            m_rel   = 4'b0000;
            for (int j = 0; j < SC; j++) m_hist[j] = 4'b0000;
            for (int c = 0; c < 4; c++) m_cnt[c] = 4'd0;
        end else begin
            if (LAT == 2) s = m_sync2;
            else          s = key_in;
            m_sync2 = m_sync1;
            m_sync1 = key_in;
            for (int j = SC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = s;
            m_press = 4'b0000;
            m_rel   = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                all_diff = 1'b1;
                for (int j = 0; j < SC; j++)
                    if (m_hist[j][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_level[c]) begin
                        m_rel[c] = 1'b1;
                    end else begin
                        m_press[c] = 1'b1;
                        m_cnt[c]   = m_cnt[c] + 4'd1;
                    end
                    m_level[c] = ~m_level[c];
                end
            end
        end
        e.level = m_level;
        e.press = m_press;
        e.rel   = m_rel;
        e.cnt   = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        sbq.push_back(model_edge());
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("sb_level",   {28'd0, key_level},   {28'd0, e.level});
        check("sb_press",   {28'd0, key_press},   {28'd0, e.press});
        check("sb_release", {28'd0, key_release}, {28'd0, e.rel});
        check("sb_cnt",     {16'd0, press_cnt},   {16'd0, e.cnt});
        for (int c = 0; c < 4; c++) begin
            press_seen[c] += int'(key_press[c]);
            rel_seen[c]   += int'(key_release[c]);
        end
    endtask

    task automatic do_clr(input int n);
        clr    = 1'b1;
        key_in = 4'b0000;
        repeat (n) tick();
        clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            press_seen[c] = 0;
            rel_seen[c]   = 0;
        end
    endtask

    // Tick until channel ch pulses; the number of ticks must equal ACC.
    task automatic wait_press(input int ch, input string name);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (key_press[ch] === 1'b1) break;
        end
        check(name, n, ACC);
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'b0000,  3, 4'b0000, 16'h0000};
        tbl[1] = '{1'b0, 4'b0001, 10, 4'b0001, 16'h0001};
        tbl[2] = '{1'b0, 4'b0000, 10, 4'b0000, 16'h0001};
        tbl[3] = '{1'b0, 4'b0101, 10, 4'b0101, 16'h0102};
        tbl[4] = '{1'b0, 4'b0000, 10, 4'b0000, 16'h0102};
        tbl[5] = '{1'b0, 4'b1111, 10, 4'b1111, 16'h1213};
        tbl[6] = '{1'b0, 4'b0000, 10, 4'b0000, 16'h1213};
        tbl[7] = '{1'b1, 4'b0000,  2, 4'b0000, 16'h0000};
        bounce = '{1, 0, 1, 1, 0};

        // Table-driven phases.
        for (int i = 0; i < 8; i++) begin
            clr    = tbl[i].clr;
            key_in = tbl[i].keys;
            repeat (tbl[i].cycles) tick();
            check($sformatf("vec%0d_level", i), {28'd0, key_level}, {28'd0, tbl[i].exp_level});
            check($sformatf("vec%0d_cnt", i),   {16'd0, press_cnt}, {16'd0, tbl[i].exp_cnt});
            if (i == 0) begin
                check("reset_press",   {28'd0, key_press},   32'd0);
                check("reset_release", {28'd0, key_release}, 32'd0);
            end
        end

        // Clean press on key 0: latency, single-cycle pulse, count.
        do_clr(2);
        key_in = 4'b0001;
        wait_press(0, "clean_latency");
        check("clean_press_vec", {28'd0, key_press}, 32'h1);
        check("clean_cnt0", {28'd0, press_cnt[3:0]}, 32'd1);
        tick();
        check("press_one_cycle", {28'd0, key_press}, 32'd0);
        key_in = 4'b0000;
        repeat (10) tick();
        check("clean_release_count", rel_seen[0], 1);

        // Keys 0 and 2 pressed in the same cycle.
        do_clr(2);
        key_in = 4'b0101;
        wait_press(0, "simul_latency");
        check("simul_press_vec", {28'd0, key_press}, 32'h5);
        check("simul_cnt", {16'd0, press_cnt}, 32'h0101);

        // Bounce on key 1, then a steady press.
        do_clr(2);
        for (int j = 0; j < 5; j++) begin
            key_in = (bounce[j] != 0) ? 4'b0010 : 4'b0000;
            tick();
        end
        key_in = 4'b0010;
        wait_press(1, "bounce_latency");
        check("bounce_pulses", press_seen[1], 1);
        check("bounce_cnt1", {28'd0, press_cnt[7:4]}, 32'd1);

        // Three-cycle glitch on key 2 must be ignored.
        do_clr(2);
        key_in = 4'b0100;
        repeat (3) tick();
        key_in = 4'b0000;
        repeat (10) tick();
        check("glitch_press", press_seen[2], 0);
        check("glitch_release", rel_seen[2], 0);
        check("glitch_level", {31'd0, key_level[2]}, 32'd0);
        check("glitch_cnt2", {28'd0, press_cnt[11:8]}, 32'd0);

        // 17 press/release cycles on key 3: counter wraps to 1.
        do_clr(2);
        for (int k = 0; k < 17; k++) begin
            key_in = 4'b1000;
            repeat (8) tick();
            key_in = 4'b0000;
            repeat (8) tick();
        end
        check("wrap_presses", press_seen[3], 17);
        check("wrap_releases", rel_seen[3], 17);
        check("wrap_cnt3", {28'd0, press_cnt[15:12]}, 32'd1);

        // clr lands on the acceptance edge of key 0, key stays held.
        do_clr(2);
        key_in = 4'b0001;
        repeat (ACC - 1) tick();
        check("pre_accept_level", {28'd0, key_level}, 32'd0);
        clr = 1'b1;
        tick();
        check("clr_accept_press", {28'd0, key_press}, 32'd0);
        check("clr_accept_level", {28'd0, key_level}, 32'd0);
        check("clr_accept_cnt",   {16'd0, press_cnt}, 32'd0);
        clr = 1'b0;
        wait_press(0, "post_clr_latency");
        check("post_clr_cnt0", {28'd0, press_cnt[3:0]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
